fft8_feeder: RTL and testbench

- Source-side sequencer for the 8-point serial FFT datapath.
- Accepts packed complex samples over a valid/ready handshake and buffers them into 8-sample frames using ping-pong banks.
- Streams each frame one sample per cycle, together with the 3-bit stage-select count and the two twiddle words the FFT stages consume.
- Inserts zero frames so the FFT pipeline drains when input runs dry.

---
 rtl/fft8_pkg.sv | 11 +
 rtl/fft8_pingpong_buf.sv | 50 +++++
 rtl/fft8_feeder.sv | 131 +++++++++++++
 tb/tb_fft8_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// fft8_pkg: shared widths, twiddle ROM, FSM states and index helper for the FFT8 feeder.
package fft8_pkg;
    localparam int CW = 16;
    localparam int HW = CW / 2;
    // Q1.6 halves {re, im}: {64,0}, {45,-45}, {0,-64}, {-45,-45}
    localparam logic [CW-1:0] TW_ROM [4] = '{16'h4000, 16'h2DD3, 16'h00C0, 16'hD3D3};
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
    function automatic logic [2:0] bitrev3(input logic [2:0] x);
        return {x[0], x[1], x[2]};
    endfunction
endpackage

// File: rtl/fft8_pingpong_buf.sv
// fft8_pingpong_buf: two 8-entry sample banks with full flags, filled by a
// valid/ready writer and released one frame at a time by the reader.
module fft8_pingpong_buf #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [N-1:0] i_wr_data,
    input  logic         i_wr_valid,
    output logic         o_wr_ready,
    input  logic [3:0]   i_rd_addr,
    input  logic         i_rd_done,
    output logic [N-1:0] o_rd_data,
    output logic         o_rd_bank,
    output logic         o_rd_full,
    output logic         o_other_full
);
    logic [N-1:0] r_mem [16];
    logic [1:0]   r_full;
    logic         r_wr_bank;
    logic         r_rd_bank;
    logic [2:0]   r_wr_idx;
    logic         w_wr;
    logic         w_wr_last;

    assign o_wr_ready   = !r_full[r_wr_bank];
    assign w_wr         = i_wr_valid && o_wr_ready;
    assign w_wr_last    = w_wr && (r_wr_idx == 3'd7);
    assign o_rd_data    = r_mem[i_rd_addr];
    assign o_rd_bank    = r_rd_bank;
    assign o_rd_full    = r_full[r_rd_bank];
    assign o_other_full = r_full[~r_rd_bank];

    always_ff @(posedge clk)
        if (w_wr) r_mem[{r_wr_bank, r_wr_idx}] <= i_wr_data;

    // a completing write and a completing read always target different banks
    always_ff @(posedge clk or posedge clear)
        if (clear) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else begin
            if (w_wr) r_wr_idx <= r_wr_idx + 3'd1;
            if (w_wr_last) r_wr_bank <= ~r_wr_bank;
            if (i_rd_done) r_rd_bank <= ~r_rd_bank;
            r_full <= (r_full | ({1'b0, w_wr_last} << r_wr_bank)) & ~({1'b0, i_rd_done} << r_rd_bank);
        end
endmodule

// File: rtl/fft8_feeder.sv
// fft8_feeder: frames input samples through ping-pong banks and streams them with sel/twiddles,
// padding with zero frames to drain the FFT. FFT_FEEDER_BITREV_EN selects bit-reversed read order.
module fft8_feeder
    import fft8_pkg::*;
#(
    parameter int N            = CW,
    parameter int FLUSH_FRAMES = 1
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] c,
    output logic [N-1:0] d,
    output logic [2:0]   sel,
    output logic         run,
    output logic         frame_start
);
    localparam int FW = (FLUSH_FRAMES > 1) ? $clog2(FLUSH_FRAMES) : 1;

    state_t         r_state;
    state_t         w_nstate;
    logic [2:0]     r_sel;
    logic [2:0]     w_nsel;
    logic [2:0]     w_idx;
    logic [FW-1:0]  r_fcnt;
    logic [FW-1:0]  w_nfcnt;
    logic           w_rd_done;
    logic           w_rd_full;
    logic           w_other_full;
    logic           w_rd_bank;
    logic [N-1:0]   w_rd_data;
    logic [N-1:0]   w_tw [4];
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_c;
    logic [N-1:0]   w_d;
    logic           w_run;
    logic           w_fs;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_c;
    logic [N-1:0]   r_d;
    logic           r_run;
    logic           r_fs;

    for (genvar k = 0; k < 4; k++) begin : g_tw
        assign w_tw[k] = {(N/2)'(signed'(TW_ROM[k][CW-1:HW])), (N/2)'(signed'(TW_ROM[k][HW-1:0]))};
    end

`ifdef FFT_FEEDER_BITREV_EN
    assign w_idx = bitrev3(w_nsel);
`else
    assign w_idx = w_nsel;
`endif

    // the address targets the bank that will be current after this edge
    fft8_pingpong_buf #(.N(N)) u_buf (
        .clk          (clk),
        .clear        (clear),
        .i_wr_data    (in_data),
        .i_wr_valid   (in_valid),
        .o_wr_ready   (in_ready),
        .i_rd_addr    ({w_rd_bank ^ w_rd_done, w_idx}),
        .i_rd_done    (w_rd_done),
        .o_rd_data    (w_rd_data),
        .o_rd_bank    (w_rd_bank),
        .o_rd_full    (w_rd_full),
        .o_other_full (w_other_full)
    );

    always_ff @(posedge clk or posedge clear)
        if (clear) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_fcnt  <= '0;
            r_a     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_run   <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_sel   <= w_nsel;
            r_fcnt  <= w_nfcnt;
            r_a     <= w_a;
            r_c     <= w_c;
            r_d     <= w_d;
            r_run   <= w_run;
            r_fs    <= w_fs;
        end

    always_comb begin
        w_nstate  = r_state;
        w_nsel    = r_sel + 3'd1;
        w_nfcnt   = r_fcnt;
        w_rd_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_nsel = '0;
                if (w_rd_full) w_nstate = STREAM;
            end
            STREAM: if (r_sel == 3'd7) begin
                w_rd_done = 1'b1;
                w_nfcnt   = '0;
                w_nstate  = w_other_full ? STREAM : (FLUSH_FRAMES == 0) ? IDLE : FLUSH;
            end
            FLUSH: if (r_sel == 3'd7) begin
                if (w_rd_full) w_nstate = STREAM;
                else if (r_fcnt == FW'(FLUSH_FRAMES - 1)) w_nstate = IDLE;
                else w_nfcnt = r_fcnt + FW'(1);
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_comb begin
        w_run = (w_nstate != IDLE);
        w_a   = (w_nstate == STREAM) ? w_rd_data : '0;
        w_c   = w_run ? w_tw[w_nsel[1:0]] : '0;
        w_d   = w_run ? w_tw[{w_nsel[0], 1'b0}] : '0;
        w_fs  = w_run && (w_nsel == 3'd0);
    end

    assign a           = r_a;
    assign c           = r_c;
    assign d           = r_d;
    assign sel         = r_sel;
    assign run         = r_run;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_fft8_feeder.sv
// tb_fft8_feeder: directed checks of framing, latency, flush padding, mid-stream clear and read order.
module tb_fft8_feeder;
    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] c;
    logic [15:0] d;
    logic [2:0]  sel;
    logic        run;
    logic        frame_start;

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] c;
        logic [15:0] d;
        logic [2:0]  sel;
        logic        fs;
    } rec_t;

    localparam logic [15:0] C_TAB [4] = '{16'h4000, 16'h2DD3, 16'h00C0, 16'hD3D3};

    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          stalls = 0;
    rec_t        rec_q[$];
    logic [15:0] exp_q[$];
    int          acc_q[$];

    always #5 clk = ~clk;

    fft8_feeder #(.N(16), .FLUSH_FRAMES(2)) dut (
        .clk         (clk),
        .clear       (clear),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .c           (c),
        .d           (d),
        .sel         (sel),
        .run         (run),
        .frame_start (frame_start)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t r;
        r.cyc = cyc;
        r.a   = a;
        r.c   = c;
        r.d   = d;
        r.sel = sel;
        r.fs  = frame_start;
        if (run) rec_q.push_back(r);
        if (in_valid && in_ready) acc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int ord(input int s);
`ifdef FFT_FEEDER_BITREV_EN
        return ((s & 1) << 2) | (s & 2) | ((s >> 2) & 1);
`else
        return s;
`endif
    endfunction

    task automatic start_test();
        rec_q.delete();
        exp_q.delete();
        acc_q.delete();
        stalls = 0;
    endtask

    task automatic push(input logic [15:0] v);
        int n = 0;
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        check("push_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] base, input logic [15:0] step);
        for (int i = 0; i < 8; i++) push(16'(base + step * i));
    endtask

    task automatic exp_frame(input logic [15:0] base, input logic [15:0] step);
        for (int s = 0; s < 8; s++) exp_q.push_back(16'(base + step * ord(s)));
    endtask

    task automatic exp_zero(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(16'h0000);
    endtask

    // outputs must form one contiguous run starting two cycles after the 8th accept
    task automatic verify(input string tag);
        int first;
        int s;
        check({tag, " accepts"}, acc_q.size() >= 8, 1);
        first = (acc_q.size() >= 8) ? acc_q[7] + 2 : 0;
        check({tag, " n_out"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
            s = i % 8;
            check($sformatf("%s a[%0d]", tag, i), rec_q[i].a, exp_q[i]);
            check($sformatf("%s sel[%0d]", tag, i), rec_q[i].sel, s);
            check($sformatf("%s c[%0d]", tag, i), rec_q[i].c, C_TAB[s % 4]);
            check($sformatf("%s d[%0d]", tag, i), rec_q[i].d, (s % 2) ? 16'h00C0 : 16'h4000);
            check($sformatf("%s fs[%0d]", tag, i), rec_q[i].fs, s == 0);
            check($sformatf("%s cyc[%0d]", tag, i), rec_q[i].cyc, first + i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        tick(3);
        check("rst a", a, 0);
        check("rst c", c, 0);
        check("rst d", d, 0);
        check("rst sel", sel, 0);
        check("rst run", run, 0);
        check("rst fs", frame_start, 0);
        clear = 1'b0;
        tick(1);
        check("rst in_ready", in_ready, 1);

        // single frame, then two zero frames, then idle
        start_test();
        push_frame(16'h0101, 16'h0101);
        exp_frame(16'h0101, 16'h0101);
        exp_zero(16);
        tick(40);
        check("single stalls", stalls, 0);
        verify("single");
        check("single idle run", run, 0);
        check("single idle sel", sel, 0);
        check("single idle c", c, 0);

        // 24 back-to-back writes: one stall while both banks are full
        start_test();
        push_frame(16'h1000, 16'h0001);
        push_frame(16'h1008, 16'h0001);
        push_frame(16'h1010, 16'h0001);
        exp_frame(16'h1000, 16'h0001);
        exp_frame(16'h1008, 16'h0001);
        exp_zero(8);
        exp_frame(16'h1010, 16'h0001);
        exp_zero(16);
        tick(60);
        check("burst stalls", stalls, 1);
        verify("burst");
        check("burst idle run", run, 0);

        // second frame completes part way through the flush frame
        start_test();
        push_frame(16'h2000, 16'h0001);
        tick(4);
        push_frame(16'h3000, 16'h0001);
        exp_frame(16'h2000, 16'h0001);
        exp_zero(8);
        exp_frame(16'h3000, 16'h0001);
        exp_zero(16);
        tick(50);
        verify("midflush");
        check("midflush idle run", run, 0);

        // clear in the middle of a streaming frame
        start_test();
        push_frame(16'h5000, 16'h0001);
        n = 0;
        while (!(run && sel == 3'd4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("clr sel4 seen", run && sel == 3'd4, 1);
        clear = 1'b1;
        #1;
        check("clr a", a, 0);
        check("clr c", c, 0);
        check("clr d", d, 0);
        check("clr sel", sel, 0);
        check("clr run", run, 0);
        check("clr fs", frame_start, 0);
        tick(2);
        clear = 1'b0;
        rec_q.delete();
        tick(1);
        check("clr in_ready", in_ready, 1);
        tick(30);
        check("clr no stale", rec_q.size(), 0);
        check("clr run idle", run, 0);

        // re = index frame after clear exposes read order
        start_test();
        push_frame(16'h0000, 16'h0100);
        exp_frame(16'h0000, 16'h0100);
        exp_zero(16);
        tick(40);
        verify("order");
        check("order idle run", run, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
